// File: rtl/wb_stream_pkg.sv
// Shared types and Wishbone encodings for the stream-to-BlockRAM burst writer.
package wb_stream_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [3:0] SEL_ALL     = 4'hF;

endpackage

// File: rtl/stream_fifo.sv
// Synchronous FIFO with registered occupancy count; head is read straight from the array.
module stream_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/wb_stream_writer.sv
// Stream-in, Wishbone incrementing-burst writer into a frame region of BlockRAM.
// Define WB_STREAM_WRITER_SOF_RESYNC_EN to restart the frame address on s_sof-tagged words.
module wb_stream_writer
  import wb_stream_pkg::*;
#(
  parameter logic [31:0] BASE_ADR    = 32'h0000_0000,
  parameter int          FRAME_WORDS = 1024,
  parameter int          BURST_LEN   = 8,
  parameter int          FIFO_DEPTH  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        s_sof,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [31:0] wb_adr,
  output logic [31:0] wb_dat_ms,
  output logic [3:0]  wb_sel,
  output logic [2:0]  wb_cti,
  output logic [1:0]  wb_bte,
  input  logic        wb_ack,
  output logic        frame_done
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [31:0] LAST_ADR = BASE_ADR + 32'(4 * (FRAME_WORDS - 1));
`ifdef WB_STREAM_WRITER_SOF_RESYNC_EN
  localparam int FW = 33;
`else
  localparam int FW = 32;
`endif

  state_t        state_q, state_d;
  logic [31:0]   adr_q, adr_d;
  logic [BW-1:0] beat_q, beat_d;
  logic          frame_done_q, frame_done_d;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [FW-1:0] fifo_din, fifo_head;
  logic          in_burst, last_beat, head_sof;
  logic [31:0]   cur_adr;

  assign fifo_push = s_valid && !fifo_full;

`ifdef WB_STREAM_WRITER_SOF_RESYNC_EN
  assign fifo_din = {s_sof, s_data};
  assign head_sof = fifo_head[32];
`else
  logic sof_unused;
  assign sof_unused = s_sof;
  assign fifo_din   = s_data;
  assign head_sof   = 1'b0;
`endif

  stream_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (fifo_head)
  );

  assign in_burst  = (state_q == BURST);
  assign last_beat = (beat_q == BW'(BURST_LEN - 1));
  // A start-of-frame word overrides the running address for its own beat.
  assign cur_adr   = (in_burst && head_sof) ? BASE_ADR : adr_q;

  always_comb begin
    state_d      = state_q;
    adr_d        = adr_q;
    beat_d       = beat_q;
    frame_done_d = 1'b0;
    fifo_pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fifo_count >= CW'(BURST_LEN)) state_d = BURST;
      end
      BURST: begin
        if (wb_ack && !fifo_empty) begin
          fifo_pop = 1'b1;
          if (cur_adr == LAST_ADR) begin
            adr_d        = BASE_ADR;
            frame_done_d = 1'b1;
          end else begin
            adr_d = cur_adr + 32'd4;
          end
          if (last_beat) begin
            beat_d  = '0;
            state_d = IDLE;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      adr_q        <= BASE_ADR;
      beat_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      adr_q        <= adr_d;
      beat_q       <= beat_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign s_ready    = !fifo_full;
  assign wb_cyc     = in_burst;
  assign wb_stb     = in_burst;
  assign wb_we      = in_burst;
  assign wb_sel     = SEL_ALL;
  assign wb_bte     = BTE_LINEAR;
  assign wb_cti     = !in_burst ? CTI_CLASSIC : (last_beat ? CTI_END : CTI_INCR);
  assign wb_adr     = cur_adr;
  assign wb_dat_ms  = fifo_head[31:0];
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_wb_stream_writer.sv
// Directed bench for wb_stream_writer with a same-cycle-ack BlockRAM slave model.
module tb_wb_stream_writer;

  localparam logic [31:0] BASE = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        s_sof = 1'b0;
  logic        wb_cyc, wb_stb, wb_we, wb_ack;
  logic [31:0] wb_adr, wb_dat_ms;
  logic [3:0]  wb_sel;
  logic [2:0]  wb_cti;
  logic [1:0]  wb_bte;
  logic        frame_done;
  logic        ack_en = 1'b1;

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] mon_adr[$];
  logic [31:0] mon_dat[$];
  logic [2:0]  mon_cti[$];
  int          fd_at[$];

  always #5 clk = ~clk;

  assign wb_ack = wb_cyc & wb_stb & ack_en;

  wb_stream_writer #(
    .BASE_ADR    (BASE),
    .FRAME_WORDS (16),
    .BURST_LEN   (8),
    .FIFO_DEPTH  (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_sof      (s_sof),
    .wb_cyc     (wb_cyc),
    .wb_stb     (wb_stb),
    .wb_we      (wb_we),
    .wb_adr     (wb_adr),
    .wb_dat_ms  (wb_dat_ms),
    .wb_sel     (wb_sel),
    .wb_cti     (wb_cti),
    .wb_bte     (wb_bte),
    .wb_ack     (wb_ack),
    .frame_done (frame_done)
  );

  // Beats are recorded on the falling edge, committed by the DUT on the next rising edge.
  always @(negedge clk) begin
    if (wb_cyc && wb_stb && wb_ack) begin
      mon_adr.push_back(wb_adr);
      mon_dat.push_back(wb_dat_ms);
      mon_cti.push_back(wb_cti);
    end
    if (frame_done) fd_at.push_back(mon_adr.size());
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_mon();
    mon_adr.delete();
    mon_dat.delete();
    mon_cti.delete();
    fd_at.delete();
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_sof   = 1'b0;
    step(3);
    rst_n = 1'b1;
    clear_mon();
    step(1);
  endtask

  task automatic push(input logic [31:0] d, input logic sof);
    int   c;
    logic rdy;
    c       = 0;
    s_data  = d;
    s_sof   = sof;
    s_valid = 1'b1;
    do begin
      rdy = s_ready;
      step(1);
      c++;
    end while (!rdy && c < 300);
    s_valid = 1'b0;
    s_sof   = 1'b0;
    check("push_accept", {31'b0, rdy}, 32'd1);
  endtask

  task automatic wait_beats(input string tag, input int n, input int max_cyc);
    int c;
    c = 0;
    while (mon_adr.size() < n && c < max_cyc) begin
      step(1);
      c++;
    end
    step(12);
    check({tag, "_beats"}, mon_adr.size(), n);
  endtask

  task automatic check_beats(input string tag, input int n, input logic [31:0] dat0);
    for (int i = 0; i < n && i < mon_adr.size(); i++) begin
      check($sformatf("%s_adr[%0d]", tag, i), mon_adr[i], BASE + 32'(4 * (i % 16)));
      check($sformatf("%s_dat[%0d]", tag, i), mon_dat[i], dat0 + 32'(i));
      check($sformatf("%s_cti[%0d]", tag, i), {29'b0, mon_cti[i]},
            ((i % 8) == 7) ? 32'd7 : 32'd2);
    end
  endtask

  initial begin
    logic cyc_seen;
    int   c;

    // Reset values.
    rst_n = 1'b0;
    step(2);
    check("rst_cyc", {31'b0, wb_cyc}, 32'd0);
    check("rst_stb", {31'b0, wb_stb}, 32'd0);
    check("rst_cti", {29'b0, wb_cti}, 32'd0);
    check("rst_adr", wb_adr, BASE);
    check("rst_ready", {31'b0, s_ready}, 32'd1);
    check("rst_fdone", {31'b0, frame_done}, 32'd0);
    do_reset();

    // One 8-beat burst from 8 back-to-back words.
    for (int i = 0; i < 8; i++) push(32'hA0 + 32'(i), 1'b0);
    wait_beats("burst", 8, 100);
    check_beats("burst", 8, 32'hA0);
    check("burst_sel", {28'b0, wb_sel}, 32'hF);
    check("burst_bte", {30'b0, wb_bte}, 32'd0);
    check("burst_fdone", fd_at.size(), 0);

    // Five words must not start a burst; three more complete it.
    do_reset();
    for (int i = 0; i < 5; i++) push(32'hB0 + 32'(i), 1'b0);
    cyc_seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      cyc_seen |= wb_cyc;
      step(1);
    end
    check("partial_cyc", {31'b0, cyc_seen}, 32'd0);
    for (int i = 5; i < 8; i++) push(32'hB0 + 32'(i), 1'b0);
    wait_beats("partial", 8, 100);
    check_beats("partial", 8, 32'hB0);

    // Backpressure: slave stalls, FIFO fills to 16, word 17 waits.
    do_reset();
    ack_en = 1'b0;
    for (int i = 0; i < 16; i++) push(32'hC00 + 32'(i), 1'b0);
    check("bp_ready_full", {31'b0, s_ready}, 32'd0);
    s_data  = 32'hC10;
    s_valid = 1'b1;
    step(5);
    check("bp_ready_held", {31'b0, s_ready}, 32'd0);
    check("bp_no_beats", mon_adr.size(), 0);
    check("bp_cyc_waiting", {31'b0, wb_cyc}, 32'd1);
    s_valid = 1'b0;
    ack_en  = 1'b1;
    for (int i = 16; i < 20; i++) push(32'hC00 + 32'(i), 1'b0);
    wait_beats("bp", 16, 200);
    check_beats("bp", 16, 32'hC00);
    check("bp_fdone_cnt", fd_at.size(), 1);
    if (fd_at.size() > 0) check("bp_fdone_at", fd_at[0], 16);

    // Frame wrap over 17 bursts with a 16-word frame.
    do_reset();
    for (int i = 0; i < 136; i++) push(32'h1000 + 32'(i), 1'b0);
    wait_beats("wrap", 136, 400);
    check_beats("wrap", 136, 32'h1000);
    check("wrap_word16_adr", (mon_adr.size() > 16) ? mon_adr[16] : 32'hDEAD, BASE);
    check("wrap_fdone_cnt", fd_at.size(), 8);
    for (int k = 0; k < fd_at.size(); k++)
      check($sformatf("wrap_fdone_at[%0d]", k), fd_at[k], 16 * (k + 1));

    // Reset during beat 3 of a burst.
    do_reset();
    for (int i = 0; i < 8; i++) push(32'hD0 + 32'(i), 1'b0);
    c = 0;
    while (mon_adr.size() < 3 && c < 100) begin
      step(1);
      c++;
    end
    check("mid_cyc_before", {31'b0, wb_cyc}, 32'd1);
    check("mid_adr_before", wb_adr, BASE + 32'hC);
    rst_n = 1'b0;
    #1;
    check("mid_cyc_async", {31'b0, wb_cyc}, 32'd0);
    check("mid_stb_async", {31'b0, wb_stb}, 32'd0);
    check("mid_adr_async", wb_adr, BASE);
    check("mid_ready", {31'b0, s_ready}, 32'd1);
    step(2);
    rst_n = 1'b1;
    clear_mon();
    step(1);
    for (int i = 0; i < 8; i++) push(32'hE0 + 32'(i), 1'b0);
    wait_beats("post_rst", 8, 100);
    check_beats("post_rst", 8, 32'hE0);

`ifdef WB_STREAM_WRITER_SOF_RESYNC_EN
    // Start-of-frame on word 5 restarts the address at BASE.
    do_reset();
    for (int i = 0; i < 10; i++) push(32'hF0 + 32'(i), (i == 5));
    wait_beats("sof", 8, 100);
    for (int i = 0; i < 8 && i < mon_adr.size(); i++) begin
      check($sformatf("sof_adr[%0d]", i), mon_adr[i],
            (i < 5) ? BASE + 32'(4 * i) : BASE + 32'(4 * (i - 5)));
      check($sformatf("sof_dat[%0d]", i), mon_dat[i], 32'hF0 + 32'(i));
    end
    check("sof_fdone", fd_at.size(), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_stream_writer.md
Name: wb_stream_writer

Overview:
- Wishbone burst master that sits directly upstream of the on-chip BlockRAM slave.
- Takes a 32-bit pixel/word stream (valid/ready) and buffers it in a small FIFO.
- Writes the words as incrementing-address bursts into a frame region of the RAM.
- Pulses a frame-done flag each time a full frame has been written.

Parameters:
- BASE_ADR, 32'h0000_0000, byte address of first word of frame region (word aligned)
- FRAME_WORDS, 1024, words per frame; must be a multiple of BURST_LEN
- BURST_LEN, 8, beats per Wishbone burst; power of 2, ≤ FIFO_DEPTH
- FIFO_DEPTH, 16, input FIFO depth in words; power of 2

Ports:
- clk  in  1  system clock, shared with Wishbone bus
- rst_n  in  1  asynchronous active-low reset
- s_data  in  32  stream word
- s_valid  in  1  stream word valid
- s_ready  out  1  stream ready (FIFO not full)
- s_sof  in  1  start-of-frame tag on current word
- wb_cyc  out  1  Wishbone cycle
- wb_stb  out  1  Wishbone strobe
- wb_we  out  1  write enable (constant 1 during cycles)
- wb_adr  out  32  byte address
- wb_dat_ms  out  32  write data
- wb_sel  out  4  byte select (always 4'b1111)
- wb_cti  out  3  cycle type identifier
- wb_bte  out  2  burst type (always 2'b00, linear)
- wb_ack  in  1  slave acknowledge
- frame_done  out  1  one-cycle pulse after last word of a frame acked

Behaviour:
- Single clock clk; reset rst_n asynchronous, active-low. Already decided.
- Reset values:
  - wb_cyc = wb_stb = 0, wb_cti = 3'b000, wb_adr = BASE_ADR.
  - FIFO empty, s_ready = 1 once out of reset, frame_done = 0.
  - Beat counter = 0, state IDLE.
- Stream side:
  - Word accepted when s_valid && s_ready.
  - s_ready = !fifo_full (registered count).
  - Simultaneous push and pop leaves the count unchanged.
  - A push when full is impossible by construction.
- FSM states: IDLE, BURST.
- IDLE:
  - cyc/stb low.
  - Go to BURST when fifo_count ≥ BURST_LEN (count as it stood at the end of the previous cycle).
  - At least one IDLE cycle always separates two bursts.
- BURST:
  - cyc = stb = we = 1, sel = 4'hF.
  - dat_ms = FIFO head (combinational from register array).
  - adr = current write address.
  - cti = 3'b010 on beats 0..BURST_LEN-2; cti = 3'b111 on the final beat.
  - Each cycle with wb_ack: pop FIFO, address += 4, beat counter += 1.
  - No ack means the beat is held unchanged (slave wait states allowed).
  - After final-beat ack: return to IDLE, beat counter = 0.
- Latency:
  - BRAM acks writes in the same cycle, so a burst takes BURST_LEN cycles plus 1 IDLE cycle.
  - First burst starts 2 cycles after the BURST_LEN-th word is pushed.
- Address wrap:
  - When an acked beat's address equals BASE_ADR + 4*(FRAME_WORDS-1), next address = BASE_ADR.
  - frame_done pulses high for exactly the following cycle.
  - A wrap is always burst-aligned.
- No partial bursts: the FIFO residue below BURST_LEN waits for more data.
- Reset asserted mid-burst: cyc/stb drop immediately (asynchronously), FIFO contents discarded, address returns to BASE_ADR.

Optional Feature:
- Macro: WB_STREAM_WRITER_SOF_RESYNC_EN.
- Defined:
  - FIFO is 33 bits wide and stores s_sof with each word.
  - A beat whose stored sof = 1 is issued at wb_adr = BASE_ADR regardless of the running address; the next address becomes BASE_ADR+4.
  - The rest of the burst continues normally.
  - frame_done does not pulse on a resync.
- Undefined:
  - s_sof is ignored and the FIFO is 32 bits wide.
  - Address only wraps by count.

Decomposition:
- Package wb_stream_pkg:
  - State enum type (IDLE, BURST).
  - Constants CTI_CLASSIC = 3'b000, CTI_INCR = 3'b010, CTI_END = 3'b111, BTE_LINEAR = 2'b00.
- Sub-module stream_fifo: synchronous FIFO, parameters WIDTH and DEPTH; ports push/pop/full/empty/count/head. Same clk/rst_n.

Test Plan:
- Burst formation: push 8 words 32'hA0..A7 back-to-back → exactly one 8-beat burst.
  - adr = 0x000..0x01C step 4.
  - cti = 010 ×7 then 111.
  - BRAM words 0..7 read back A0..A7.
- No partial burst: push 5 words → cyc stays 0 for 50 cycles; push 3 more → burst with all 8 words in order.
- Backpressure: push 20 words continuously while wb_ack is held 0.
  - s_ready drops after the 16th accepted word.
  - Release ack → all 16 written in order, no loss or duplication.
- Frame wrap (FRAME_WORDS = 16): stream 17 bursts' worth of words.
  - frame_done pulses at cycles after word 15 and word 31 acks.
  - Word 16 lands at BASE_ADR.
- Reset mid-burst: assert rst_n low during beat 3 → cyc = 0 the same cycle, fifo empty, adr = BASE_ADR; the next 8 words are written at BASE_ADR onward.
- With WB_STREAM_WRITER_SOF_RESYNC_EN: push 10 words, sof on word 5 → word 5 written at BASE_ADR, word 6 at BASE_ADR+4, no frame_done.
